// File: rtl/alu_seq_param.sv
// Multi-cycle parametrised ALU: single-cycle logic/arith ops plus iterative unsigned
// multiply and restoring divide, with valid/ready on both sides and registered outputs.
module alu_seq_param #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [3:0]      op_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  // Single-cycle datapath, evaluated on the live inputs at the accept edge.
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] sc_result;
  logic             sc_carry;
  logic             sc_ovf;

  assign add_sum = {1'b0, a} + {1'b0, b};
  assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
  // Sign of the inverted operand feeding the adder, so a-b with b = MIN still flags correctly.
  assign sub_ovf = (a[WIDTH-1] == ~b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    sc_result = '0;
    sc_carry  = 1'b0;
    sc_ovf    = 1'b0;
    case (alu_ctrl)
      OP_AND: sc_result = a & b;
      OP_OR:  sc_result = a | b;
      OP_NOR: sc_result = ~(a | b);
      OP_ADD: begin
        sc_result = add_sum[WIDTH-1:0];
        sc_carry  = add_sum[WIDTH];
        sc_ovf    = add_ovf;
      end
      OP_SUB: begin
        sc_result = sub_sum[WIDTH-1:0];
        sc_carry  = ~sub_sum[WIDTH];
        sc_ovf    = sub_ovf;
      end
      OP_SLT: sc_result = {{(WIDTH-1){1'b0}}, sub_sum[WIDTH-1] ^ sub_ovf};
      default: sc_result = '0;
    endcase
  end

  // One iteration step of shift-add multiply or restoring divide.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ok    = div_shift >= {1'b0, opnd_q};
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    if (op_q == OP_MULU) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else begin
      // With a zero divisor every step subtracts nothing, leaving quotient all ones
      // and the remainder equal to the dividend.
      step_hi = div_ok ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_ok};
    end
  end

  assign in_ready = (state == IDLE);

  // NOTE: sequential state uses non-blocking assignments only; the datapath registers are
  // reset too so the outputs are defined zeros straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      opnd_q    <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      div_zero  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q <= alu_ctrl;
            if (alu_ctrl == OP_MULU || alu_ctrl == OP_DIVU) begin
              cnt    <= CW'(WIDTH - 1);
              acc_hi <= '0;
              acc_lo <= (alu_ctrl == OP_MULU) ? b : a;
              opnd_q <= (alu_ctrl == OP_MULU) ? a : b;
              state  <= BUSY;
            end else begin
              result    <= sc_result;
              result_hi <= '0;
              zero      <= (sc_result == '0);
              carry_out <= sc_carry;
              overflow  <= sc_ovf;
              div_zero  <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        BUSY: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          if (cnt == '0) begin
            result    <= step_lo;
            result_hi <= step_hi;
            zero      <= (step_lo == '0);
            carry_out <= 1'b0;
            overflow  <= (op_q == OP_MULU) && (step_hi != '0);
            div_zero  <= (op_q == OP_DIVU) && (opnd_q == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
